// File: rtl/attn_pkg.sv
// attn_pkg: shared definitions for the attention weighted-sum stage.
//   - FSM state encoding (IDLE/MAC/DONE)
//   - width helpers for the accumulator and the loop counters
//   - Q-format helper for the value 1.0
// Optional feature macro used by the consumers of this package: ATTN_WSUM_SAT_EN.
package attn_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter width able to index 0..n-1; never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Full product precision plus headroom for summing n products.
    function automatic int acc_width(input int data_w, input int n);
        return 2 * data_w + ((n <= 1) ? 0 : $clog2(n));
    endfunction

    // Integer encoding of 1.0 for a given number of fractional bits.
    function automatic int q_one(input int frac_w);
        return 1 << frac_w;
    endfunction

endpackage

// File: rtl/attn_fixmac.sv
// attn_fixmac: signed fixed-point multiply-accumulate with narrowing.
//   clk, rst  : clock / synchronous active-high reset
//   i_clr     : clear accumulator (new job)
//   i_en      : accumulate i_a*i_b this cycle
//   i_last    : this product closes the current sum; accumulator clears after it
//   i_a, i_b  : signed operands (DATA_WIDTH)
//   o_q       : combinational (acc + i_a*i_b) >>> FRAC_WIDTH, narrowed to DATA_WIDTH
// Macro ATTN_WSUM_SAT_EN: saturate the narrowed value instead of wrapping.
module attn_fixmac
    import attn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int ACC_WIDTH  = 35
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic                  i_last,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_q
);

    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    w_sum;
    logic signed [ACC_WIDTH-1:0]    w_shift;

    assign w_prod  = $signed(i_a) * $signed(i_b);
    assign w_sum   = r_acc + ACC_WIDTH'(w_prod);
    // Arithmetic shift: floor toward -inf, so -0.5 LSB lands on -1.
    assign w_shift = w_sum >>> FRAC_WIDTH;

`ifdef ATTN_WSUM_SAT_EN
    // In range only if every bit above the target sign bit matches it.
    logic [ACC_WIDTH-DATA_WIDTH:0] w_hi;
    logic                          w_ovf;
    assign w_hi  = w_shift[ACC_WIDTH-1:DATA_WIDTH-1];
    assign w_ovf = !((&w_hi) || (~|w_hi));
    always_comb begin
        o_q = w_shift[DATA_WIDTH-1:0];
        if (w_ovf)
            o_q = w_shift[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                       : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`else
    assign o_q = w_shift[DATA_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= i_last ? '0 : w_sum;
    end

endmodule

// File: rtl/attn_weighted_sum.sv
// attn_weighted_sum: O = S*V with one shared fixed-point MAC.
//   clk, rst            : clock / synchronous active-high reset
//   in_valid, in_ready  : input handshake for the S_in/V_in pair
//   S_in                : TOKEN_NUM x TOKEN_NUM scores, element (r,c) at (r*TOKEN_NUM+c)*DATA_WIDTH
//   V_in                : TOKEN_NUM x TOKEN_DIM values, element (k,d) at (k*TOKEN_DIM+d)*DATA_WIDTH
//   O_out               : TOKEN_NUM x TOKEN_DIM result, held between jobs
//   out_valid, out_ready: output handshake
//   busy                : high while the MAC is running
// Macro ATTN_WSUM_SAT_EN: saturating narrowing of each output element.
module attn_weighted_sum
    import attn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int TOKEN_DIM  = 4,
    parameter int TOKEN_NUM  = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_WIDTH*TOKEN_NUM*TOKEN_NUM-1:0] S_in,
    input  logic [DATA_WIDTH*TOKEN_NUM*TOKEN_DIM-1:0] V_in,
    output logic [DATA_WIDTH*TOKEN_NUM*TOKEN_DIM-1:0] O_out,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   busy
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, TOKEN_NUM);
    localparam int CW_N      = cnt_width(TOKEN_NUM);
    localparam int CW_D      = cnt_width(TOKEN_DIM);
    localparam logic [CW_N-1:0] N_LAST = CW_N'(TOKEN_NUM - 1);
    localparam logic [CW_D-1:0] D_LAST = CW_D'(TOKEN_DIM - 1);

    // Packed 3-D arrays share the flat bus bit layout, so capture is a plain copy.
    logic [TOKEN_NUM-1:0][TOKEN_NUM-1:0][DATA_WIDTH-1:0] r_s;
    logic [TOKEN_NUM-1:0][TOKEN_DIM-1:0][DATA_WIDTH-1:0] r_v;
    logic [TOKEN_NUM-1:0][TOKEN_DIM-1:0][DATA_WIDTH-1:0] r_o;
    logic [1:0]      r_state;
    logic            r_in_rdy;
    logic [CW_N-1:0] r_i;
    logic [CW_N-1:0] r_k;
    logic [CW_D-1:0] r_d;

    logic                  w_accept;
    logic                  w_mac;
    logic                  w_k_last;
    logic                  w_d_last;
    logic                  w_i_last;
    logic [DATA_WIDTH-1:0] w_q;

    assign w_accept = (r_state == ST_IDLE) && in_valid && r_in_rdy;
    assign w_mac    = (r_state == ST_MAC);
    assign w_k_last = (r_k == N_LAST);
    assign w_d_last = (r_d == D_LAST);
    assign w_i_last = (r_i == N_LAST);

    // in_ready is its own register so it stays low for the first cycle
    // after reset drops and never depends combinationally on rst.
    assign in_ready  = r_in_rdy;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = w_mac;
    assign O_out     = r_o;

    attn_fixmac #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_accept),
        .i_en   (w_mac),
        .i_last (w_k_last),
        .i_a    (r_s[r_i][r_k]),
        .i_b    (r_v[r_k][r_d]),
        .o_q    (w_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_in_rdy <= 1'b0;
            r_i      <= '0;
            r_k      <= '0;
            r_d      <= '0;
            r_s      <= '0;
            r_v      <= '0;
            r_o      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_rdy <= 1'b1;
                    if (w_accept) begin
                        r_s      <= S_in;
                        r_v      <= V_in;
                        r_i      <= '0;
                        r_k      <= '0;
                        r_d      <= '0;
                        r_in_rdy <= 1'b0;
                        r_state  <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    // k innermost, then d, then i.
                    if (w_k_last) begin
                        r_o[r_i][r_d] <= w_q;
                        r_k           <= '0;
                        if (w_d_last) begin
                            r_d <= '0;
                            if (w_i_last) begin
                                r_i     <= '0;
                                r_state <= ST_DONE;
                            end else begin
                                r_i <= r_i + CW_N'(1);
                            end
                        end else begin
                            r_d <= r_d + CW_D'(1);
                        end
                    end else begin
                        r_k <= r_k + CW_N'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state  <= ST_IDLE;
                        r_in_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_in_rdy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_attn_weighted_sum.sv
// Testbench for attn_weighted_sum: directed jobs with hand-derived results,
// expected matrices queued at issue and compared by an output monitor.
module tb_attn_weighted_sum;

    localparam int DW = 16;
    localparam int FW = 8;
    localparam int TD = 4;
    localparam int TN = 8;
    localparam int N  = TN * TN * TD;

    typedef logic [TN-1:0][TN-1:0][DW-1:0] smat_t;
    typedef logic [TN-1:0][TD-1:0][DW-1:0] vmat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  in_valid = 1'b0;
    logic  out_ready = 1'b1;
    smat_t s_in = '0;
    vmat_t v_in = '0;
    vmat_t o_out;
    logic  in_ready, out_valid, busy;

    always #5 clk = ~clk;

    attn_weighted_sum #(
        .DATA_WIDTH (DW),
        .FRAC_WIDTH (FW),
        .TOKEN_DIM  (TD),
        .TOKEN_NUM  (TN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S_in      (s_in),
        .V_in      (v_in),
        .O_out     (o_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    vmat_t exp_q[$];
    vmat_t mon_exp;
    int    n_vec  = 0;
    int    n_miss = 0;

    task automatic chk(input string nm, input logic [TN*TD*DW-1:0] act, input logic [TN*TD*DW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Monitor: one pop per output handshake (sampled mid-cycle).
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_result: got %h with no job pending", o_out);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("result", o_out, mon_exp);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input smat_t s, input vmat_t v);
        int t;
        s_in = s;
        v_in = v;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        chk("in_ready_wait", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain;
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 600) begin
            tick();
            t++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic job(input smat_t s, input vmat_t v, input vmat_t e);
        exp_q.push_back(e);
        accept(s, v);
        drain();
    endtask

    function automatic smat_t s_all(input logic [DW-1:0] x);
        smat_t m;
        for (int r = 0; r < TN; r++)
            for (int c = 0; c < TN; c++)
                m[r][c] = x;
        return m;
    endfunction

    function automatic vmat_t v_all(input logic [DW-1:0] x);
        vmat_t m;
        for (int r = 0; r < TN; r++)
            for (int c = 0; c < TD; c++)
                m[r][c] = x;
        return m;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        smat_t s_id, s_r;
        vmat_t v_id, v_r, e_r, v_sat;
        logic [DW-1:0] sat_val;
        int cnt;

        for (int r = 0; r < TN; r++)
            for (int c = 0; c < TN; c++)
                s_id[r][c] = (r == c) ? 16'h0100 : 16'h0000;
        for (int k = 0; k < TN; k++)
            for (int d = 0; d < TD; d++)
                v_id[k][d] = DW'(k * 16 + d);

        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_O", o_out, '0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Identity scores: O = V, result visible N cycles after acceptance
        exp_q.push_back(v_id);
        accept(s_id, v_id);
        chk("mac_busy", busy, 1'b1);
        chk("mac_in_ready", in_ready, 1'b0);
        cnt = 0;
        while (!out_valid && cnt < 400) begin
            tick();
            cnt++;
        end
        chk("latency", cnt, N);
        drain();

        // Uniform 1/8 scores
        job(s_all(16'h0020), v_all(16'h0100), v_all(16'h0100));
        job(s_all(16'h0020), v_all(16'hFF00), v_all(16'hFF00));

        // Floor on the fractional shift: +0.5 LSB -> 0, -0.5 LSB -> -1
        s_r = '0;
        s_r[0][0] = 16'h0080;
        v_r = '0;
        e_r = '0;
        for (int d = 0; d < TD; d++) v_r[0][d] = 16'h0001;
        job(s_r, v_r, e_r);
        for (int d = 0; d < TD; d++) begin
            v_r[0][d] = 16'hFFFF;
            e_r[0][d] = 16'hFFFF;
        end
        job(s_r, v_r, e_r);

        // Overflow: 8 * 0x7000 = 0x38000 after the shift
`ifdef ATTN_WSUM_SAT_EN
        sat_val = 16'h7FFF;
`else
        sat_val = 16'h8000;
`endif
        v_sat = v_all(sat_val);
        job(s_all(16'h0100), v_all(16'h7000), v_sat);

        // Backpressure: result held, second request ignored until release
        out_ready = 1'b0;
        exp_q.push_back(v_all(16'h0100));
        accept(s_all(16'h0020), v_all(16'h0100));
        cnt = 0;
        while (!out_valid && cnt < 400) begin
            tick();
            cnt++;
        end
        chk("bp_out_valid_wait", out_valid, 1'b1);
        exp_q.push_back(v_id);
        s_in = s_id;
        v_in = v_id;
        in_valid = 1'b1;
        repeat (10) begin
            tick();
            chk("bp_hold_O", o_out, v_all(16'h0100));
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        tick();
        chk("release_in_ready", in_ready, 1'b1);
        chk("release_out_valid", out_valid, 1'b0);
        tick();
        chk("second_busy", busy, 1'b1);
        in_valid = 1'b0;
        drain();

        // Reset in the middle of a job discards it
        accept(s_all(16'h0100), v_all(16'h0100));
        repeat (99) tick();
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_O", o_out, '0);
        chk("midrst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        chk("rst_drop_in_ready", in_ready, 1'b0);
        tick();
        chk("rst_drop_next_in_ready", in_ready, 1'b1);
        job(s_all(16'h0020), v_all(16'hFF00), v_all(16'hFF00));

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
